// File: rtl/reg_writeback_if.sv
// Bus bundle for the register-file write-side driver: ALU result stream,
// load issue/return streams, register-file write port and scoreboard outputs.
interface reg_writeback_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                          alu_valid;
    logic [ADDRESS_WIDTH-1:0]      alu_rd;
    logic [DATA_WIDTH-1:0]         alu_data;
    logic                          ld_issue;
    logic [ADDRESS_WIDTH-1:0]      ld_issue_rd;
    logic                          ld_valid;
    logic                          ld_ready;
    logic [ADDRESS_WIDTH-1:0]      ld_rd;
    logic [DATA_WIDTH-1:0]         ld_data;
    logic                          WE3;
    logic [ADDRESS_WIDTH-1:0]      AD3;
    logic [DATA_WIDTH-1:0]         WD3;
    logic [2**ADDRESS_WIDTH-1:0]   rd_pending;
    logic [15:0]                   blocked_cnt;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_issue_rd,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        output WE3, AD3, WD3,
        output rd_pending, blocked_cnt
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_issue_rd,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        input  WE3, AD3, WD3,
        input  rd_pending, blocked_cnt
    );
endinterface

// File: rtl/reg_writeback.sv
// Register-file write driver: ALU results take priority, loads wait in a small FIFO.
// Optional macro WB_BLOCKED_CNT_EN enables the saturating load-blocked cycle counter.
module reg_writeback #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    reg_writeback_if.slave  wb
);
    localparam int NREG = 2**ADDRESS_WIDTH;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [ADDRESS_WIDTH-1:0] fifo_rd_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];

    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] ad_q, ad_d;
    logic [DATA_WIDTH-1:0]    wd_q, wd_d;
    logic [NREG-1:0]          pend_q, pend_d;

    logic                     enq;
    logic                     deq;
    logic [ADDRESS_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0]    head_data;

    // Readiness looks only at the registered count, so a full FIFO refuses even on a dequeue cycle.
    assign wb.ld_ready = !rst && (count_q < DEPTH_C);

    always_comb begin
        enq       = wb.ld_valid && wb.ld_ready;
        deq       = !wb.alu_valid && (count_q != '0);
        head_rd   = fifo_rd_q[rd_ptr_q];
        head_data = fifo_data_q[rd_ptr_q];

        we_d = 1'b0;
        ad_d = ad_q;
        wd_d = wd_q;
        if (wb.alu_valid) begin
            we_d = (wb.alu_rd != '0);
            ad_d = wb.alu_rd;
            wd_d = wb.alu_data;
        end else if (deq) begin
            we_d = (head_rd != '0);
            ad_d = head_rd;
            wd_d = head_data;
        end

        wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(enq) - CW'(deq);

        // Clear before set so a same-cycle issue to the dequeued register stays pending.
        pend_d = pend_q;
        if (deq && head_rd != '0) begin
            pend_d[head_rd] = 1'b0;
        end
        if (wb.ld_issue && wb.ld_issue_rd != '0) begin
            pend_d[wb.ld_issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            ad_q     <= '0;
            wd_q     <= '0;
            pend_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            ad_q     <= ad_d;
            wd_q     <= wd_d;
            pend_q   <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd_q[wr_ptr_q]   <= wb.ld_rd;
            fifo_data_q[wr_ptr_q] <= wb.ld_data;
        end
    end

    assign wb.WE3        = we_q;
    assign wb.AD3        = ad_q;
    assign wb.WD3        = wd_q;
    assign wb.rd_pending = pend_q;

`ifdef WB_BLOCKED_CNT_EN
    logic [15:0] blk_q, blk_d;

    always_comb begin
        blk_d = blk_q;
        if (wb.alu_valid && count_q != '0 && blk_q != 16'hFFFF) begin
            blk_d = blk_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q <= '0;
        end else begin
            blk_q <= blk_d;
        end
    end

    assign wb.blocked_cnt = blk_q;
`else
    assign wb.blocked_cnt = '0;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: a behavioural model predicts each cycle's
// write-port, pending and counter values, which are queued and compared after the edge.
module tb_reg_writeback;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    typedef struct {
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        logic [31:0]   pend;
        logic [15:0]   blk;
    } exp_t;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ld_t;

    logic clk;
    logic rst;

    reg_writeback_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) w ();

    reg_writeback #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t          exp_q [$];
    ld_t           mq    [$];
    ld_t           prod_q[$];
    logic [AW-1:0] m_ad;
    logic [DW-1:0] m_wd;
    logic [31:0]   m_pend;
    logic [15:0]   m_blk;
    int            n_checks;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: predict from current inputs, advance, compare against the prediction.
    task automatic step();
        exp_t e;
        ld_t  h;
        int   pre;
        logic ready_m;
        logic acc;
        if (prod_q.size() > 0) begin
            w.ld_valid = 1'b1;
            w.ld_rd    = prod_q[0].rd;
            w.ld_data  = prod_q[0].data;
        end else begin
            w.ld_valid = 1'b0;
        end
        #1;
        pre     = mq.size();
        ready_m = !rst && (pre < DEPTH);
        check("ld_ready", w.ld_ready, ready_m);
        if (w.alu_valid)
            check("no_waw", (w.alu_rd != 0) && w.rd_pending[w.alu_rd], 0);
        acc  = w.ld_valid && ready_m;
        e.we = 1'b0;
        if (rst) begin
            mq.delete();
            m_pend = '0;
            m_blk  = '0;
            m_ad   = '0;
            m_wd   = '0;
        end else begin
`ifdef WB_BLOCKED_CNT_EN
            if (w.alu_valid && pre > 0 && m_blk != 16'hFFFF) m_blk = m_blk + 16'd1;
`endif
            if (w.alu_valid) begin
                e.we = (w.alu_rd != 0);
                m_ad = w.alu_rd;
                m_wd = w.alu_data;
            end else if (pre > 0) begin
                h    = mq.pop_front();
                e.we = (h.rd != 0);
                m_ad = h.rd;
                m_wd = h.data;
                if (h.rd != 0) m_pend[h.rd] = 1'b0;
            end
            if (w.ld_issue && w.ld_issue_rd != 0) m_pend[w.ld_issue_rd] = 1'b1;
            if (acc) mq.push_back('{w.ld_rd, w.ld_data});
        end
        e.ad   = m_ad;
        e.wd   = m_wd;
        e.pend = m_pend;
        e.blk  = m_blk;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("WE3", w.WE3, e.we);
        check("AD3", w.AD3, e.ad);
        check("WD3", w.WD3, e.wd);
        check("rd_pending", w.rd_pending, e.pend);
        check("blocked_cnt", w.blocked_cnt, e.blk);
        if (acc) void'(prod_q.pop_front());
        w.alu_valid = 1'b0;
        w.ld_issue  = 1'b0;
    endtask

    task automatic alu(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        w.alu_valid = 1'b1;
        w.alu_rd    = rd;
        w.alu_data  = data;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        w.ld_issue    = 1'b1;
        w.ld_issue_rd = rd;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((mq.size() > 0 || prod_q.size() > 0) && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_timeout", (mq.size() > 0 || prod_q.size() > 0), 0);
        step();
    endtask

    initial begin
        logic [AW-1:0] r;
        logic          do_issue;
        n_checks      = 0;
        n_fail        = 0;
        m_ad          = '0;
        m_wd          = '0;
        m_pend        = '0;
        m_blk         = '0;
        rst           = 1'b1;
        w.alu_valid   = 1'b0;
        w.alu_rd      = '0;
        w.alu_data    = '0;
        w.ld_issue    = 1'b0;
        w.ld_issue_rd = '0;
        w.ld_valid    = 1'b0;
        w.ld_rd       = '0;
        w.ld_data     = '0;
        #1;

        // Reset held two cycles with a load waiting; accepted right after release.
        prod_q.push_back('{5'd1, 32'h0000_0055});
        step();
        step();
        check("reset_pend", w.rd_pending, 0);
        rst = 1'b0;
        step();
        drain(10);

        // ALU only.
        alu(5'd5, 32'hDEADBEEF);
        step();
        check("alu_wd", w.WD3, 32'hDEADBEEF);
        step();
        check("alu_idle_we", w.WE3, 0);

        // Load path with issue, return and scoreboard clear.
        issue(5'd10);
        step();
        check("pend10_set", w.rd_pending[10], 1);
        step();
        prod_q.push_back('{5'd10, 32'h12345678});
        step();
        step();
        check("ld_wd", w.WD3, 32'h12345678);
        check("pend10_clr", w.rd_pending[10], 0);
        step();

        // Contention: ALU busy four cycles, two loads fill the FIFO, a third waits.
        issue(5'd3);
        step();
        issue(5'd4);
        step();
        issue(5'd9);
        step();
        prod_q.push_back('{5'd3, 32'h3333_0003});
        prod_q.push_back('{5'd4, 32'h4444_0004});
        prod_q.push_back('{5'd9, 32'h9999_0009});
        alu(5'd1, 32'hA001); step();
        alu(5'd2, 32'hA002); step();
        alu(5'd6, 32'hA006); step();
        alu(5'd8, 32'hA008); step();
        drain(10);

        // x0 writes: ALU and load to register 0, issue to register 0.
        alu(5'd0, 32'hAAAA_0000);
        issue(5'd0);
        step();
        check("x0_pend0", w.rd_pending[0], 0);
        prod_q.push_back('{5'd0, 32'hBBBB_0000});
        drain(10);

        // Same-cycle clear and set of register 7.
        issue(5'd7);
        step();
        prod_q.push_back('{5'd7, 32'h7777_0007});
        step();
        issue(5'd7);
        step();
        check("pend7_set_wins", w.rd_pending[7], 1);
        step();

        // Reset mid-operation with a buffered load.
        issue(5'd12);
        step();
        prod_q.push_back('{5'd12, 32'hC0DE_000C});
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("midrst_pend", w.rd_pending, 0);

        // Randomised traffic exercising pointer wrap and blocking.
        for (int i = 0; i < 400; i++) begin
            r = AW'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0 && !(r != 0 && m_pend[r])) alu(r, $urandom);
            do_issue = ($urandom_range(0, 2) == 0) && (prod_q.size() < 3);
            r = AW'($urandom_range(0, 31));
            if (do_issue) issue(r);
            step();
            if (do_issue) prod_q.push_back('{r, $urandom});
        end
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side driver for the 32-entry register file: owns the WE3/AD3/WD3 write port.
- Merges the single-cycle ALU result stream with a multi-cycle load-return stream into one registered write per cycle.
- Buffers loads in a small FIFO. Tracks in-flight load destinations in a pending scoreboard that the hazard logic reads.

Parameters:
- DATA_WIDTH, 32, width of register data.
- ADDRESS_WIDTH, 5, register index width; register count = 2**ADDRESS_WIDTH.
- FIFO_DEPTH, 2, load-return buffer entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- alu_valid  input  1  ALU result valid this cycle; never stalled.
- alu_rd  input  ADDRESS_WIDTH  ALU destination register.
- alu_data  input  DATA_WIDTH  ALU result.
- ld_issue  input  1  load issued to memory this cycle.
- ld_issue_rd  input  ADDRESS_WIDTH  destination of issued load.
- ld_valid  input  1  load data returning.
- ld_ready  output  1  FIFO can accept load data.
- ld_rd  input  ADDRESS_WIDTH  destination of returning load.
- ld_data  input  DATA_WIDTH  returning load data.
- WE3  output  1  register-file write enable, registered.
- AD3  output  ADDRESS_WIDTH  register-file write address, registered.
- WD3  output  DATA_WIDTH  register-file write data, registered.
- rd_pending  output  2**ADDRESS_WIDTH  bit i set = load to register i in flight.
- blocked_cnt  output  16  load-blocked cycle counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at posedge):
  - WE3=0, AD3=0, WD3=0.
  - FIFO empty, read/write pointers 0, count 0.
  - rd_pending=0, blocked_cnt=0.
  - ld_ready=0 while rst is high; ld_ready=1 in the first cycle after rst deasserts.
  - Reset mid-operation discards all buffered loads and pending bits.
- Load acceptance:
  - ld_ready = !rst && (count < FIFO_DEPTH), from current-state count only.
  - When full, not ready, even if a dequeue happens the same cycle.
  - Enqueue on ld_valid && ld_ready.
  - ld_valid while not ready: producer holds its data; nothing is lost.
- Arbitration, evaluated each cycle:
  - alu_valid=1: write the ALU result; the FIFO head does not dequeue.
  - else count>0: write the FIFO head and dequeue it.
  - else: no write.
  - The selected write appears on WE3/AD3/WD3 at the next posedge, so latency is 1 cycle.
  - A load enqueued into an empty FIFO, with no ALU write, is written no earlier than 2 cycles after acceptance (enqueue cycle, then head-write cycle).
- x0 rule:
  - A selected write with rd=0 still consumes its slot or dequeues its entry.
  - It produces WE3=0. AD3/WD3 are still updated.
- No-write cycle: WE3=0; AD3/WD3 hold their previous values.
- FIFO pointers wrap modulo FIFO_DEPTH. Simultaneous enqueue and dequeue leaves count unchanged.
- Scoreboard:
  - ld_issue with ld_issue_rd != 0 sets that bit.
  - Dequeue of a FIFO entry with rd != 0 clears that bit.
  - Set and clear of the same bit in one cycle: set wins.
  - Bit 0 is always 0.
- Ordering:
  - Upstream hazard logic stalls any ALU op whose rd is pending, so no WAW race reaches this block.
  - The bench asserts that alu_valid && rd_pending[alu_rd] && alu_rd != 0 never occurs.
- Widths: no arithmetic on data. count is $clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: WB_BLOCKED_CNT_EN.
- Defined:
  - blocked_cnt increments each cycle that alu_valid=1 and count>0.
  - Saturates at 16'hFFFF; cleared by rst.
- Undefined: blocked_cnt is tied to 0 and no counter logic exists. The port is present in both builds.

Test Plan:
- Reset: hold rst 2 cycles with ld_valid=1 -> ld_ready=0, WE3=0, AD3=0, WD3=0, rd_pending=0; the cycle after release, ld_ready=1.
- ALU only: alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF -> next cycle WE3=1, AD3=5, WD3=32'hDEADBEEF; following idle cycle WE3=0.
- Load path: ld_issue rd=10 -> rd_pending[10]=1. Two cycles later ld_valid rd=10, data=32'h12345678 -> WE3=1, AD3=10, WD3=32'h12345678 two cycles after acceptance; rd_pending[10] clears on the dequeue edge.
- Contention/full:
  - Stimulus: alu_valid held 4 cycles; loads rd=3 then rd=4 enqueued.
  - Response: ld_ready=0 after 2 entries; writes go to ALU first.
  - Then rd=3 writes, then rd=4 writes, in order.
  - With WB_BLOCKED_CNT_EN, blocked_cnt increases by one per blocked cycle.
- x0: ALU rd=0 and load rd=0 -> WE3 stays 0; load entry still dequeued; ld_issue rd=0 never sets rd_pending[0].
- Same-cycle set/clear: dequeue of rd=7 in the same cycle as ld_issue rd=7 -> rd_pending[7] remains 1.
